// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: serial subtractor state encoding,
// default operand width and a constant-evaluable clog2.
package arith_pkg;

  localparam int unsigned SUB_WIDTH = 16;

  localparam logic [1:0] SUB_IDLE = 2'd0;
  localparam logic [1:0] SUB_RUN  = 2'd1;
  localparam logic [1:0] SUB_DONE = 2'd2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/binary_sub_16_serial_fs_bit.sv
// One-bit combinational full subtractor cell: diff = a - b - bin.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/binary_sub_16_serial.sv
// Bit-serial WIDTH-bit subtractor D = A - B, one bit per clock through a single
// full-subtractor cell, with start/busy/done handshake.
module binary_sub_16_serial
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned CW = clog2(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             bin;

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH-1:0] r_next;
  logic             last_bit;

  fs_bit u_fs_bit (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bin),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  always_comb begin
    r_next   = {cell_diff, r_sh[WIDTH-1:1]};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // On the final bit the operand LSBs are the original MSBs, which is what
  // the overflow rule needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SUB_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      D      <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        SUB_IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            cnt   <= '0;
            bin   <= 1'b0;
            state <= SUB_RUN;
          end
        end
        SUB_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_next;
          bin  <= cell_bout;
          if (last_bit) begin
            D      <= r_next;
            borrow <= cell_bout;
            ovf    <= (a_sh[0] != b_sh[0]) && (cell_diff != a_sh[0]);
            cnt    <= '0;
            state  <= SUB_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SUB_DONE: state <= SUB_IDLE;
        default:  state <= SUB_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == SUB_RUN) || (state == SUB_DONE);
    done = (state == SUB_DONE);
  end

endmodule

// File: tb/tb_binary_sub_16_serial.sv
// Self-checking bench for binary_sub_16_serial against an arithmetic model.
module tb_binary_sub_16_serial;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         borrow;
  logic         ovf;

  int n_checks;
  int n_errors;

  binary_sub_16_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .D      (D),
    .borrow (borrow),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W-1:0] ref_d(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned t;
    t = (int'(a) - int'(b) + 65536) % 65536;
    return W'(t);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
    return int'(a) < int'(b);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = int'($signed(a)) - int'($signed(b));
    return (s > 32767) || (s < -32768);
  endfunction

  // One operation: start at a negedge, optionally scramble inputs (and start)
  // while busy, then check latency, busy span, results and single done pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    int cyc;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    seen = 0;
    while (cyc < 40) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        break;
      end
      if (noise) begin
        A = W'($urandom);
        B = W'($urandom);
        start = 1'($urandom);
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'd16);
    check("busy_span", 32'(busy_cnt), 32'd17);
    check("D", 32'(D), 32'(ref_d(a, b)));
    check("borrow", 32'(borrow), 32'(ref_borrow(a, b)));
    check("ovf", 32'(ovf), 32'(ref_ovf(a, b)));
    @(negedge clk);
    check("done_pulse_end", 32'(done), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("no_extra_done", 32'(done), 32'd0);
    end
    check("D_hold", 32'(D), 32'(ref_d(a, b)));
  endtask

  initial begin
    int t_last;
    int pulses;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h0034, 0);
    run_op(16'h0000, 16'h0001, 0);
    run_op(16'hFFFF, 16'hFFFF, 0);
    run_op(16'h8000, 16'h0001, 0);
    run_op(16'h7FFF, 16'hFFFF, 0);
    run_op(16'h00F0, 16'h000F, 1);

    for (int i = 0; i < 12; i++) begin
      run_op(W'($urandom), W'($urandom), bit'(i % 2));
    end

    // Reset mid-operation discards the partial result.
    @(negedge clk);
    start = 1'b1;
    A = 16'h5555;
    B = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_D", 32'(D), 32'd0);
    check("midrst_borrow", 32'(borrow), 32'd0);
    repeat (20) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    run_op(16'h0003, 16'h0002, 0);

    // start held high: one completion every 18 cycles.
    @(negedge clk);
    start = 1'b1;
    A = 16'h0010;
    B = 16'h0001;
    pulses = 0;
    t_last = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        check("held_D", 32'(D), 32'h000F);
        if (t_last >= 0) check("held_period", 32'(c - t_last), 32'd18);
        t_last = c;
      end
    end
    start = 1'b0;
    check("held_pulses", 32'(pulses), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
